icap_cfg_sequencer: RTL

//  Sequences writes into the 8-bit ICAP primitive for partial reconfiguration: sync header,

---
 rtl/icap_cfg_sequencer.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/icap_cfg_sequencer.sv
// ICAP partial-reconfiguration write sequencer: sync header, streamed payload with
// BUSY back-pressure and timeout, then desync trailer, on the 8-bit ICAP port.
module icap_cfg_sequencer #(
    parameter int BUSY_TIMEOUT = 1024,
    parameter int CNT_W        = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [7:0]       s_data_i,
    input  logic             s_valid_i,
    input  logic             s_last_i,
    output logic             s_ready_o,
    input  logic             icap_busy_i,
    output logic             icap_ce_o,
    output logic             icap_write_o,
    output logic [7:0]       icap_i_o,
    output logic             active_o,
    output logic             done_o,
    output logic             error_o,
    output logic [CNT_W-1:0] byte_cnt_o
);

    localparam int            BW        = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [BW-1:0] BUSY_LAST = BW'(BUSY_TIMEOUT - 1);
    localparam logic [3:0]    HDR_LAST  = 4'd5;
    localparam logic [3:0]    TRL_LAST  = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_HDR,
        ST_DATA,
        ST_TRL,
        ST_REL,
        ST_ERR
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        idx_q, idx_d;
    logic [BW-1:0]     busy_cnt_q, busy_cnt_d;
    logic              abort_q, abort_d;
    logic              last_q, last_d;
    logic              ce_q, ce_d;
    logic              write_q, write_d;
    logic [7:0]        data_q, data_d;
    logic              active_q, active_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;

    logic presented, taken, stalled, timeout, abort_now, hdr_handoff, accept;

    // Sync word preceded by dummy/bus-width bytes.
    function automatic logic [7:0] hdr_byte(input logic [3:0] i);
        case (i)
            4'd0, 4'd1: hdr_byte = 8'hFF;
            4'd2:       hdr_byte = 8'hAA;
            4'd3:       hdr_byte = 8'h99;
            4'd4:       hdr_byte = 8'h55;
            default:    hdr_byte = 8'h66;
        endcase
    endfunction

    // Write CMD register with DESYNC, then two NOOPs to flush the pipeline.
    function automatic logic [7:0] trl_byte(input logic [3:0] i);
        case (i)
            4'd0:        trl_byte = 8'h30;
            4'd2:        trl_byte = 8'h80;
            4'd3:        trl_byte = 8'h01;
            4'd7:        trl_byte = 8'h0D;
            4'd8, 4'd12: trl_byte = 8'h20;
            default:     trl_byte = 8'h00;
        endcase
    endfunction

    assign presented   = !ce_q;
    assign taken       = presented && !icap_busy_i;
    assign stalled     = presented && icap_busy_i;
    assign timeout     = stalled && (busy_cnt_q == BUSY_LAST);
    assign abort_now   = abort_q || (abort_i && state_q != ST_IDLE);
    // Letting the first payload beat in while 0x66 leaves keeps header and payload back-to-back.
    assign hdr_handoff = (state_q == ST_HDR) && (idx_q == HDR_LAST) && taken;
    assign s_ready_o   = (state_q == ST_DATA || hdr_handoff) && !abort_now && !last_q && !stalled;
    assign accept      = s_valid_i && s_ready_o;

    // NOTE: every register uses <= so all of them sample the same pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            busy_cnt_q <= '0;
            abort_q    <= 1'b0;
            last_q     <= 1'b0;
            ce_q       <= 1'b1;
            write_q    <= 1'b1;
            data_q     <= '0;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            byte_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            busy_cnt_q <= busy_cnt_d;
            abort_q    <= abort_d;
            last_q     <= last_d;
            ce_q       <= ce_d;
            write_q    <= write_d;
            data_q     <= data_d;
            active_q   <= active_d;
            done_q     <= done_d;
            error_q    <= error_d;
            byte_cnt_q <= byte_cnt_d;
        end
    end

    // NOTE: each always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) state_d = ST_SETUP;
            end
            ST_SETUP: begin
                state_d = abort_now ? ST_TRL : ST_HDR;
                idx_d   = '0;
            end
            ST_HDR: begin
                if (timeout) begin
                    state_d = ST_ERR;
                end else if (taken) begin
                    if (idx_q == HDR_LAST) begin
                        state_d = abort_now ? ST_TRL : ST_DATA;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            ST_DATA: begin
                // A byte already on the ICAP bus always finishes before leaving DATA.
                if (timeout) begin
                    state_d = ST_ERR;
                end else if (presented ? (taken && (last_q || abort_now)) : abort_now) begin
                    state_d = ST_TRL;
                    idx_d   = '0;
                end
            end
            ST_TRL: begin
                if (timeout) begin
                    state_d = ST_ERR;
                end else if (taken) begin
                    if (idx_q == TRL_LAST) state_d = ST_REL;
                    else                   idx_d   = idx_q + 4'd1;
                end
            end
            ST_REL, ST_ERR: state_d = ST_IDLE;
            default:        state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ce_d       = 1'b1;
        write_d    = (state_d == ST_IDLE);
        data_d     = data_q;
        last_d     = 1'b0;
        active_d   = (state_d != ST_IDLE);
        done_d     = (state_q == ST_REL) && !abort_now;
        error_d    = ((state_q == ST_REL) && abort_now) || (state_q == ST_ERR);
        abort_d    = (state_d != ST_IDLE) && abort_now;
        busy_cnt_d = stalled ? busy_cnt_q + 1'b1 : '0;
        byte_cnt_d = byte_cnt_q;

        case (state_d)
            ST_HDR: begin
                ce_d   = 1'b0;
                data_d = hdr_byte(idx_d);
            end
            ST_TRL: begin
                ce_d   = 1'b0;
                data_d = trl_byte(idx_d);
            end
            ST_DATA: begin
                if (accept) begin
                    ce_d   = 1'b0;
                    data_d = s_data_i;
                    last_d = s_last_i;
                end else if (stalled) begin
                    ce_d   = 1'b0;
                    last_d = last_q;
                end
            end
            default: ;
        endcase

        if (state_q == ST_IDLE && start_i) begin
            byte_cnt_d = '0;
        end else if (state_q == ST_DATA && taken && !(&byte_cnt_q)) begin
            byte_cnt_d = byte_cnt_q + 1'b1;
        end
    end

    assign icap_ce_o    = ce_q;
    assign icap_write_o = write_q;
    assign icap_i_o     = data_q;
    assign active_o     = active_q;
    assign done_o       = done_q;
    assign error_o      = error_q;
    assign byte_cnt_o   = byte_cnt_q;

endmodule
